// File: rtl/prog_comb_pkg.sv
// Shared definitions for the programmer channel combiner:
// downlink state encoding, width helpers and default parameters.
package prog_comb_pkg;

    localparam int DEF_N_CH   = 4;
    localparam int DEF_DATA_W = 801;
    localparam int DEF_DEPTH  = 8;

    // Downlink FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;

    typedef enum logic [1:0] {
        DL_IDLE    = ST_IDLE,
        DL_FETCH   = ST_FETCH,
        DL_DELIVER = ST_DELIVER
    } dl_state_e;

    // Channel index width; a single channel still needs one bit
    function automatic int cw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy counter width able to hold 0..depth
    function automatic int lvl_w_f(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prog_rr_arbiter.sv
// Round-robin grant: first requesting channel at or after the pointer.
module prog_rr_arbiter
    import prog_comb_pkg::*;
#(
    parameter  int N_CH = DEF_N_CH,
    localparam int CW   = cw_f(N_CH)
) (
    input  logic [N_CH-1:0] request,
    input  logic [CW-1:0]   pointer,
    output logic [N_CH-1:0] grant
);

    logic found;
    int   idx;

    // Scan from the pointer, wrapping, and grant the first requester
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(pointer) + k) % N_CH;
            if (!found && request[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_channel_combiner.sv
// Programmer channel combiner: N_CH uplink channels are round-robin
// merged through a small FIFO into a transmit FIFO; received words are
// delivered to the channels through a shared downlink register.
// Optional feature macro CH_TAG_EN: uplink words carry the source
// channel index in the top bits and downlink words are routed by tag.
module prog_channel_combiner
    import prog_comb_pkg::*;
#(
    parameter  int N_CH   = DEF_N_CH,
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int CW     = cw_f(N_CH),
    localparam int LW     = lvl_w_f(DEPTH),
`ifdef CH_TAG_EN
    localparam int TX_W   = DATA_W + CW
`else
    localparam int TX_W   = DATA_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   ch_data_in,
    input  logic [N_CH-1:0]          ch_valid_in,
    output logic [N_CH-1:0]          ch_ready_out,
    output logic [DATA_W-1:0]        ch_data_out,
    output logic [N_CH-1:0]          ch_valid_out,
    input  logic [N_CH-1:0]          ch_ready_in,
    output logic [TX_W-1:0]          tx_data,
    output logic                     tx_enable,
    input  logic                     tx_empty,
    input  logic [TX_W-1:0]          rx_data,
    output logic                     rx_enable,
    input  logic                     rx_empty,
    output logic [LW-1:0]            fifo_level,
    output logic                     rx_drop
);

    localparam int AW = $clog2(DEPTH);

    // ---------------- uplink ----------------
    logic [N_CH-1:0]   grant;
    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     gnt_idx;
    logic [DATA_W-1:0] gnt_data;
    logic [TX_W-1:0]   push_word;
    logic              push, pop, can_push;

    logic [TX_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [TX_W-1:0]   tx_data_q;
    logic              tx_enable_q;

    prog_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .request (ch_valid_in),
        .pointer (rr_ptr_q),
        .grant   (grant)
    );

    // A full FIFO still accepts when the head leaves in the same cycle
    assign pop          = (level_q != '0) && tx_empty;
    assign can_push     = (level_q < LW'(DEPTH)) || pop;
    assign ch_ready_out = can_push ? grant : '0;
    assign push         = |(ch_valid_in & ch_ready_out);

    // Select the granted channel's index and word
    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                gnt_idx  = CW'(i);
                gnt_data = ch_data_in[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef CH_TAG_EN
    assign push_word = {gnt_idx, gnt_data};
`else
    assign push_word = gnt_data;
`endif

    // Next-state for pointers, occupancy and arbitration pointer
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rr_ptr_d = rr_ptr_q;
        if (push)
            rr_ptr_d = (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; emptiness is tracked by the pointers, so no reset
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= push_word;
    end

    // Uplink state and registered transmit port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rr_ptr_q    <= '0;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rr_ptr_q    <= rr_ptr_d;
            tx_enable_q <= pop;
            if (pop)
                tx_data_q <= mem_q[rd_ptr_q];
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_enable  = tx_enable_q;
    assign fifo_level = level_q;

    // ---------------- downlink ----------------
    logic [1:0]        state_q, state_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [N_CH-1:0]   rx_mask;
    logic              tag_ok;
    logic              armed_q;
    logic              rx_en_c, drop_c;

`ifdef CH_TAG_EN
    logic [CW-1:0] rx_tag;
    assign rx_tag = rx_data[TX_W-1 -: CW];
    assign tag_ok = (int'(rx_tag) < N_CH);

    // One-hot destination decoded from the word's tag
    always_comb begin
        rx_mask = '0;
        for (int i = 0; i < N_CH; i++)
            rx_mask[i] = (int'(rx_tag) == i);
    end
`else
    assign tag_ok  = 1'b1;
    assign rx_mask = '1;
`endif

    // Downlink FSM: fetch one word, hold it until every target consumed it
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        dout_d  = dout_q;
        rx_en_c = 1'b0;
        drop_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && !rx_empty) begin
                    rx_en_c = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                dout_d = rx_data[DATA_W-1:0];
                pend_d = tag_ok ? rx_mask : '0;
                if (tag_ok) begin
                    state_d = ST_DELIVER;
                end else begin
                    drop_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DELIVER: begin
                pend_d = pend_q & ~ch_ready_in;
                if (pend_d == '0)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Downlink state; armed_q blocks a read strobe in the first cycle out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            dout_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            armed_q <= 1'b1;
        end
    end

    assign rx_enable    = rx_en_c;
    assign rx_drop      = drop_c;
    assign ch_valid_out = pend_q;
    assign ch_data_out  = dout_q;

endmodule

// File: tb/tb_prog_channel_combiner.sv
// Bench for prog_channel_combiner: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_prog_channel_combiner;

`ifdef CH_TAG_EN
    localparam int N_CH = 3;
`else
    localparam int N_CH = 4;
`endif
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(N_CH);
    localparam int LW     = $clog2(DEPTH + 1);
`ifdef CH_TAG_EN
    localparam int TX_W   = DATA_W + CW;
`else
    localparam int TX_W   = DATA_W;
`endif

    logic                   clk, rst_n;
    logic [N_CH*DATA_W-1:0] ch_data_in;
    logic [N_CH-1:0]        ch_valid_in, ch_ready_out, ch_valid_out, ch_ready_in;
    logic [DATA_W-1:0]      ch_data_out;
    logic [TX_W-1:0]        tx_data, rx_data;
    logic                   tx_enable, tx_empty, rx_enable, rx_empty, rx_drop;
    logic [LW-1:0]          fifo_level;

    prog_channel_combiner #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_data_in(ch_data_in), .ch_valid_in(ch_valid_in), .ch_ready_out(ch_ready_out),
        .ch_data_out(ch_data_out), .ch_valid_out(ch_valid_out), .ch_ready_in(ch_ready_in),
        .tx_data(tx_data), .tx_enable(tx_enable), .tx_empty(tx_empty),
        .rx_data(rx_data), .rx_enable(rx_enable), .rx_empty(rx_empty),
        .fifo_level(fifo_level), .rx_drop(rx_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int rx_en_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [TX_W-1:0] tagw(input int ch, input logic [DATA_W-1:0] d);
`ifdef CH_TAG_EN
        return {CW'(ch), d};
`else
        return TX_W'(d) | TX_W'(ch * 0);
`endif
    endfunction

    // ---------------- reference model ----------------
    logic [TX_W-1:0]   mq[$];
    int                mptr;
    logic              m_txen;
    logic [TX_W-1:0]   m_txd;
    int                mph;      // 0 idle, 1 fetch, 2 deliver
    logic [N_CH-1:0]   mpend;
    logic [DATA_W-1:0] mdout;
    bit                marm;

    function automatic int m_grant();
        for (int k = 0; k < N_CH; k++)
            if (ch_valid_in[(mptr + k) % N_CH]) return (mptr + k) % N_CH;
        return -1;
    endfunction

    function automatic bit m_can();
        return (mq.size() < DEPTH) || (mq.size() > 0 && tx_empty);
    endfunction

    function automatic bit m_tag_bad();
`ifdef CH_TAG_EN
        return int'(rx_data[TX_W-1 -: CW]) >= N_CH;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        int g;
        bit acc, pv;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete(); mptr = 0; m_txen = 0; m_txd = '0;
                mph = 0; mpend = '0; mdout = '0; marm = 0;
            end else begin
                g   = m_grant();
                acc = (g >= 0) && m_can();
                pv  = (mq.size() > 0) && tx_empty;
                if (pv) m_txd = mq.pop_front();
                m_txen = pv;
                if (acc) begin
                    mq.push_back(tagw(g, ch_data_in[g*DATA_W +: DATA_W]));
                    mptr = (g + 1) % N_CH;
                end
                case (mph)
                    0: if (marm && !rx_empty) mph = 1;
                    1: begin
                        mdout = rx_data[DATA_W-1:0];
`ifdef CH_TAG_EN
                        if (m_tag_bad()) begin mpend = '0; mph = 0; end
                        else begin mpend = '0; mpend[rx_data[TX_W-1 -: CW]] = 1'b1; mph = 2; end
`else
                        mpend = '1; mph = 2;
`endif
                    end
                    default: begin
                        mpend = mpend & ~ch_ready_in;
                        if (mpend == '0) mph = 0;
                    end
                endcase
                marm = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        int cg;
        logic [N_CH-1:0] erdy;
        forever begin
            @(negedge clk);
            cg = m_grant();
            erdy = '0;
            if (cg >= 0 && m_can()) erdy[cg] = 1'b1;
            if (rx_enable) rx_en_cnt++;
            chk("level",    fifo_level,   mq.size());
            chk("tx_en",    tx_enable,    m_txen);
            chk("tx_data",  tx_data,      m_txd);
            chk("ready",    ch_ready_out, erdy);
            chk("rx_en",    rx_enable,    marm && mph == 0 && !rx_empty);
            chk("rx_drop",  rx_drop,      mph == 1 && m_tag_bad());
            chk("valid_out",ch_valid_out, (mph == 2) ? mpend : '0);
            chk("data_out", ch_data_out,  mdout);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [DATA_W-1:0] d);
        ch_data_in[ch*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        int n, c0;
        logic [TX_W-1:0] got[$];
        rst_n = 0; ch_data_in = '0; ch_valid_in = '0; ch_ready_in = '0;
        tx_empty = 0; rx_empty = 1; rx_data = '0;
        #12;
        chk("rst_level", fifo_level, 0);
        chk("rst_txen",  tx_enable, 0);
        chk("rst_vout",  ch_valid_out, 0);
        tick(); tick();
        rst_n = 1;
        tick();

        // all channels streaming: round-robin order, two-cycle latency
        tx_empty = 1;
        for (int i = 0; i < N_CH; i++) set_ch(i, DATA_W'(16'h1000 * (i + 1)));
        ch_valid_in = '1;
        tick();
        chk("rr_lat1", tx_enable, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_txen", tx_enable, 1);
            chk("rr_order", tx_data, tagw(k % N_CH, DATA_W'(16'h1000 * ((k % N_CH) + 1))));
        end
        ch_valid_in = '0;
        tick(); tick(); tick();

        // channel 2 streams into a stalled transmit FIFO
        tx_empty = 0; n = 0;
        for (int i = 0; i < 12; i++) begin
            set_ch(2, DATA_W'(16'h2200 + n));
            ch_valid_in = N_CH'(1) << 2;
            #1;
            if (ch_ready_out[2]) n++;
            tick();
        end
        chk("fill_cnt", n, 8);
        chk("fill_lvl", fifo_level, 8);
        chk("fill_rdy", ch_ready_out, 0);

        // full FIFO: push and pop in the same cycle
        ch_valid_in = N_CH'(1) << 1;
        set_ch(1, 16'h1100);
        tx_empty = 1;
        #1;
        chk("full_rdy", ch_ready_out, N_CH'(1) << 1);
        tick();
        chk("full_lvl", fifo_level, 8);
        chk("full_tx",  tx_data, tagw(2, 16'h2200));
        ch_valid_in = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tx_enable) got.push_back(tx_data);
        end
        chk("drain_n", got.size(), 8);
        for (int i = 0; i < 7 && i < got.size(); i++)
            chk("drain_ord", got[i], tagw(2, DATA_W'(16'h2201 + i)));
        if (got.size() == 8) chk("drain_last", got[7], tagw(1, 16'h1100));

`ifndef CH_TAG_EN
        // broadcast delivery with staggered consumers
        rx_data = 16'h005A; rx_empty = 0;
        #1;
        chk("bc_rxen", rx_enable, 1);
        c0 = rx_en_cnt;
        tick();
        chk("bc_fetch", rx_enable, 0);
        tick();
        chk("bc_vout", ch_valid_out, 4'hF);
        chk("bc_data", ch_data_out, 16'h005A);
        ch_ready_in = 4'b0001; tick(); chk("bc_v1", ch_valid_out, 4'b1110);
        ch_ready_in = 4'b0100; tick(); chk("bc_v2", ch_valid_out, 4'b1010);
        ch_ready_in = 4'b0010; tick(); chk("bc_v3", ch_valid_out, 4'b1000);
        chk("bc_onefetch", rx_en_cnt - c0, 1);
        ch_ready_in = 4'b1000; tick(); chk("bc_v4", ch_valid_out, 4'b0000);
        chk("bc_next", rx_enable, 1);
        rx_empty = 1; ch_ready_in = '0;
        tick();
`else
        // tagged delivery: out-of-range tag dropped, valid tag routed
        rx_data = {2'd3, 16'h00AA}; rx_empty = 0;
        #1;
        chk("tg_rxen", rx_enable, 1);
        tick();
        chk("tg_drop", rx_drop, 1);
        chk("tg_dvout", ch_valid_out, 0);
        rx_empty = 1;
        tick();
        chk("tg_drop0", rx_drop, 0);
        chk("tg_vout0", ch_valid_out, 0);
        rx_data = {2'd1, 16'h0055}; rx_empty = 0;
        tick();
        rx_empty = 1;
        tick();
        chk("tg_route", ch_valid_out, 3'b010);
        chk("tg_data", ch_data_out, 16'h0055);
        ch_ready_in = 3'b010; tick();
        chk("tg_done", ch_valid_out, 0);
        ch_ready_in = '0;
        tick();
`endif

        // reset in the middle of a delivery with a partly filled FIFO
        tx_empty = 0; n = 0;
        rx_data = tagw(0, 16'h0077); rx_empty = 0;
        set_ch(0, 16'h3300);
        ch_valid_in = N_CH'(1);
        for (int i = 0; i < 10 && n < 5; i++) begin
            #1;
            if (ch_ready_out[0]) n++;
            tick();
        end
        ch_valid_in = '0;
        tick();
        chk("mid_lvl", fifo_level, 5);
`ifdef CH_TAG_EN
        chk("mid_vout", ch_valid_out, 3'b001);
`else
        chk("mid_vout", ch_valid_out, 4'hF);
`endif
        #1 rst_n = 0;
        #1;
        chk("ar_lvl",  fifo_level, 0);
        chk("ar_vout", ch_valid_out, 0);
        chk("ar_txen", tx_enable, 0);
        chk("ar_rxen", rx_enable, 0);
        chk("ar_dout", ch_data_out, 0);
        tx_empty = 1;
        tick(); tick();
        rst_n = 1;
        #1;
        chk("rel_rxen", rx_enable, 0);
        chk("rel_txen", tx_enable, 0);
        tick();
        rx_empty = 1;
        ch_ready_in = '1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
